// File: rtl/segre_pkg.sv
// Shared types and sizes for the segre core writeback path: result entry layout,
// source identifiers and the wrap-safe age helper used by the arbiter.
package segre_pkg;

    localparam int WORD_SIZE     = 32;
    localparam int REG_SIZE      = 5;
    localparam int HF_PTR        = 4;
    localparam int WB_N_SRC      = 3;
    localparam int WB_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_MEM  = 2'd1,
        WB_SRC_RVM5 = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic                rf_we;
        logic [REG_SIZE-1:0] waddr;
        logic [WORD_SIZE-1:0] data;
        logic [HF_PTR-1:0]   instr_id;
    } wb_entry_t;

    // Distance from the oldest in-flight id; modular subtraction keeps it correct across wrap.
    function automatic logic [HF_PTR-1:0] wb_age(input logic [HF_PTR-1:0] id,
                                                 input logic [HF_PTR-1:0] head);
        return id - head;
    endfunction

endpackage

// File: rtl/segre_wb_fifo.sv
// Small skid FIFO of writeback entries, one per producing pipeline.
// Full is registered, so a pop only releases the producer on the following cycle.
module segre_wb_fifo
    import segre_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic      clk_i,
    input  logic      rsn_i,
    input  logic      push_i,
    input  wb_entry_t entry_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign empty_o = (count == '0);
    assign head_o  = mem[rptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            full_o <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count  <= count_next;
            full_o <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: it is only read while count marks it valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= entry_i;
    end

endmodule

// File: rtl/segre_wb_stage.sv
// Writeback stage: queues ALU/MEM/RVM5 results and retires the oldest one per cycle.
// Defining SEGRE_WB_PERF_EN adds per-source stall counters and a writeback counter.
module segre_wb_stage
    import segre_pkg::*;
#(
    parameter int N_SRC      = WB_N_SRC,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                        clk_i,
    input  logic                        rsn_i,
    input  logic [N_SRC-1:0]            src_valid_i,
    input  logic [N_SRC-1:0]            src_rf_we_i,
    input  logic [N_SRC*REG_SIZE-1:0]   src_waddr_i,
    input  logic [N_SRC*WORD_SIZE-1:0]  src_data_i,
    input  logic [N_SRC*HF_PTR-1:0]     src_instr_id_i,
    output logic [N_SRC-1:0]            src_full_o,
    input  logic [HF_PTR-1:0]           hf_head_i,
    output logic                        rf_we_o,
    output logic [REG_SIZE-1:0]         rf_waddr_o,
    output logic [WORD_SIZE-1:0]        rf_data_o,
    output logic                        hf_done_o,
    output logic [HF_PTR-1:0]           hf_done_id_o,
    output logic                        wb_bypass_we_o,
    output logic [REG_SIZE-1:0]         wb_bypass_waddr_o,
    output logic [WORD_SIZE-1:0]        wb_bypass_data_o
`ifdef SEGRE_WB_PERF_EN
    ,
    output logic [N_SRC*32-1:0]         perf_stall_cnt_o,
    output logic [31:0]                 perf_wb_cnt_o
`endif
);

    wb_entry_t          fifo_head [N_SRC];
    logic [N_SRC-1:0]   fifo_full;
    logic [N_SRC-1:0]   fifo_empty;
    logic [N_SRC-1:0]   fifo_push;
    logic [N_SRC-1:0]   fifo_pop;
    logic               win_found;
    wb_entry_t          win_entry;
    logic [HF_PTR-1:0]  best_age;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        wb_entry_t push_entry;

        assign push_entry.rf_we    = src_rf_we_i[g];
        assign push_entry.waddr    = src_waddr_i[g*REG_SIZE +: REG_SIZE];
        assign push_entry.data     = src_data_i[g*WORD_SIZE +: WORD_SIZE];
        assign push_entry.instr_id = src_instr_id_i[g*HF_PTR +: HF_PTR];
        assign fifo_push[g]        = src_valid_i[g] && !fifo_full[g];

        segre_wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rsn_i   (rsn_i),
            .push_i  (fifo_push[g]),
            .entry_i (push_entry),
            .pop_i   (fifo_pop[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g]),
            .head_o  (fifo_head[g])
        );

        // A producer that ignores full loses its result; flag it loudly.
        a_no_push_when_full: assert property (
            @(posedge clk_i) disable iff (!rsn_i) !(src_valid_i[g] && fifo_full[g]));
    end

    assign src_full_o = fifo_full;

    // Oldest head wins; strict compare leaves illegal ties to the lower source index.
    always_comb begin
        win_found = 1'b0;
        win_entry = '0;
        best_age  = '1;
        fifo_pop  = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (!fifo_empty[s] &&
                (!win_found || (wb_age(fifo_head[s].instr_id, hf_head_i) < best_age))) begin
                win_found   = 1'b1;
                win_entry   = fifo_head[s];
                best_age    = wb_age(fifo_head[s].instr_id, hf_head_i);
                fifo_pop    = '0;
                fifo_pop[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            rf_data_o    <= '0;
            hf_done_o    <= 1'b0;
            hf_done_id_o <= '0;
        end else begin
            rf_we_o   <= win_found && win_entry.rf_we && (win_entry.waddr != '0);
            hf_done_o <= win_found;
            if (win_found) begin
                rf_waddr_o   <= win_entry.waddr;
                rf_data_o    <= win_entry.data;
                hf_done_id_o <= win_entry.instr_id;
            end
        end
    end

    assign wb_bypass_we_o    = rf_we_o;
    assign wb_bypass_waddr_o = rf_waddr_o;
    assign wb_bypass_data_o  = rf_data_o;

`ifdef SEGRE_WB_PERF_EN
    logic [31:0] stall_cnt [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_perf
        always_ff @(posedge clk_i or negedge rsn_i) begin
            if (!rsn_i) begin
                stall_cnt[g] <= '0;
            end else if (fifo_full[g] && (stall_cnt[g] != '1)) begin
                stall_cnt[g] <= stall_cnt[g] + 1'b1;
            end
        end
        assign perf_stall_cnt_o[g*32 +: 32] = stall_cnt[g];
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            perf_wb_cnt_o <= '0;
        end else if (hf_done_o && (perf_wb_cnt_o != '1)) begin
            perf_wb_cnt_o <= perf_wb_cnt_o + 1'b1;
        end
    end
`endif

endmodule
